// File: rtl/atm_pkg.sv
// Shared types and encodings for the ATM session controller.
package atm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LANG,
    ST_PIN,
    ST_OP,
    ST_WDRAW,
    ST_DEP,
    ST_INQ,
    ST_ANOTHER,
    ST_EJECT,
    ST_RETAIN
  } atm_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PIN     = 3'd1;
  localparam logic [2:0] ERR_FUNDS   = 3'd2;
  localparam logic [2:0] ERR_LIMIT   = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_ILLEGAL = 3'd6;

  localparam logic [1:0] OP_WDRAW   = 2'b00;
  localparam logic [1:0] OP_DEP     = 2'b01;
  localparam logic [1:0] OP_INQ     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

endpackage

// File: rtl/atm_inactivity_timer.sv
// Idle-cycle counter; expire_o flags the last allowed idle cycle while enabled.
module atm_inactivity_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] count_q;

  assign expire_o = en_i && (count_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (en_i && !expire_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Card session sequencer: language, PIN with retries, operations, eject/retain.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned BAL_W         = 20,
  parameter int unsigned TIMEOUT_CYC   = 1000,
  parameter int unsigned PIN_TRIES     = 3,
  parameter int unsigned SESSION_LIMIT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic [BAL_W-1:0] acct_balance,
  input  logic             lang_valid,
  input  logic             language,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             op_valid,
  input  logic [1:0]       operation,
  input  logic [BAL_W-1:0] value,
  input  logic             another_valid,
  input  logic             another_service,
  output logic [BAL_W-1:0] balance,
  output logic             lang_sel,
  output logic             op_done,
  output logic             error,
  output logic [2:0]       error_code,
  output logic             card_eject,
  output logic             card_retain,
  output logic             busy
);

  localparam int unsigned W1 = BAL_W + 1;

  atm_state_e       state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] value_q, value_d;
  logic [BAL_W-1:0] withdrawn_q, withdrawn_d;
  logic [2:0]       retry_q, retry_d;
  logic [2:0]       code_q, code_d;
  logic             lang_q, lang_d;
  logic             op_done_q, op_done_d;
  logic             error_q, error_d;
  logic             eject_q, eject_d;
  logic             retain_q, retain_d;
  logic             accepted;
  logic             tmr_en, tmr_clr, tmr_expire;
  logic [BAL_W:0]   wsum, dsum;

  assign tmr_en  = (state_q == ST_LANG) || (state_q == ST_PIN) ||
                   (state_q == ST_OP)   || (state_q == ST_ANOTHER);
  assign tmr_clr = accepted || (state_d != state_q);

  atm_inactivity_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    balance_d   = balance_q;
    value_d     = value_q;
    withdrawn_d = withdrawn_q;
    retry_d     = retry_q;
    code_d      = code_q;
    lang_d      = lang_q;
    op_done_d   = 1'b0;
    error_d     = 1'b0;
    eject_d     = 1'b0;
    retain_d    = 1'b0;
    accepted    = 1'b0;
    wsum        = {1'b0, withdrawn_q} + {1'b0, value_q};
    dsum        = {1'b0, balance_q} + {1'b0, value_q};

    case (state_q)
      ST_IDLE: if (card_in) begin
        state_d     = ST_LANG;
        balance_d   = acct_balance;
        retry_d     = '0;
        withdrawn_d = '0;
        code_d      = ERR_NONE;
      end
      ST_LANG: if (lang_valid) begin
        accepted = 1'b1;
        lang_d   = language;
        state_d  = ST_PIN;
      end
      ST_PIN: if (pin_valid) begin
        accepted = 1'b1;
        if (pin_ok) begin
          retry_d = '0;
          state_d = ST_OP;
        end else begin
          error_d = 1'b1;
          code_d  = ERR_PIN;
          retry_d = retry_q + 3'd1;
          if (retry_d == 3'(PIN_TRIES)) state_d = ST_RETAIN;
        end
      end
      ST_OP: if (op_valid) begin
        accepted = 1'b1;
        value_d  = value;
        case (operation)
          OP_WDRAW: state_d = ST_WDRAW;
          OP_DEP:   state_d = ST_DEP;
          OP_INQ:   state_d = ST_INQ;
          default: begin
            error_d = 1'b1;
            code_d  = ERR_ILLEGAL;
          end
        endcase
      end
      ST_WDRAW: begin
        if (value_q > balance_q) begin
          error_d = 1'b1;
          code_d  = ERR_FUNDS;
        end else if (wsum > W1'(SESSION_LIMIT)) begin
          error_d = 1'b1;
          code_d  = ERR_LIMIT;
        end else begin
          balance_d   = balance_q - value_q;
          withdrawn_d = wsum[BAL_W-1:0];
          op_done_d   = 1'b1;
        end
        state_d = ST_ANOTHER;
      end
      ST_DEP: begin
        if (dsum[BAL_W]) begin
          error_d = 1'b1;
          code_d  = ERR_OVF;
        end else begin
          balance_d = dsum[BAL_W-1:0];
          op_done_d = 1'b1;
        end
        state_d = ST_ANOTHER;
      end
      ST_INQ: begin
        op_done_d = 1'b1;
        state_d   = ST_ANOTHER;
      end
      ST_ANOTHER: if (another_valid) begin
        accepted = 1'b1;
        state_d  = another_service ? ST_OP : ST_EJECT;
      end
      ST_EJECT: begin
        eject_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RETAIN: begin
        retain_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout only fires when no input was accepted in the same cycle.
    if (tmr_expire && !accepted) begin
      error_d = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_EJECT;
    end

    // Card removal abandons the session silently with all registers frozen.
    if ((state_q != ST_IDLE) && !card_in) begin
      state_d     = ST_IDLE;
      balance_d   = balance_q;
      value_d     = value_q;
      withdrawn_d = withdrawn_q;
      retry_d     = retry_q;
      code_d      = code_q;
      lang_d      = lang_q;
      op_done_d   = 1'b0;
      error_d     = 1'b0;
      eject_d     = 1'b0;
      retain_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      balance_q   <= '0;
      value_q     <= '0;
      withdrawn_q <= '0;
      retry_q     <= '0;
      code_q      <= ERR_NONE;
      lang_q      <= 1'b0;
      op_done_q   <= 1'b0;
      error_q     <= 1'b0;
      eject_q     <= 1'b0;
      retain_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      balance_q   <= balance_d;
      value_q     <= value_d;
      withdrawn_q <= withdrawn_d;
      retry_q     <= retry_d;
      code_q      <= code_d;
      lang_q      <= lang_d;
      op_done_q   <= op_done_d;
      error_q     <= error_d;
      eject_q     <= eject_d;
      retain_q    <= retain_d;
    end
  end

  assign balance     = balance_q;
  assign lang_sel    = lang_q;
  assign op_done     = op_done_q;
  assign error       = error_q;
  assign error_code  = code_q;
  assign card_eject  = eject_q;
  assign card_retain = retain_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with a pulse-event scoreboard.
module tb_atm_session_ctrl;

  localparam int unsigned BW = 20;

  localparam logic [3:0] K_DONE = 4'b1000;
  localparam logic [3:0] K_ERR  = 4'b0100;
  localparam logic [3:0] K_EJ   = 4'b0010;
  localparam logic [3:0] K_RET  = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          card_in = 1'b0;
  logic [BW-1:0] acct_balance = '0;
  logic          lang_valid = 1'b0;
  logic          language = 1'b0;
  logic          pin_valid = 1'b0;
  logic          pin_ok = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    operation = 2'b00;
  logic [BW-1:0] value = '0;
  logic          another_valid = 1'b0;
  logic          another_service = 1'b0;
  logic [BW-1:0] balance;
  logic          lang_sel, op_done, error, card_eject, card_retain, busy;
  logic [2:0]    error_code;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];
  logic [26:0] obs_v, exp_v;

  atm_session_ctrl #(
    .BAL_W        (BW),
    .TIMEOUT_CYC  (16),
    .PIN_TRIES    (3),
    .SESSION_LIMIT(500)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_in        (card_in),
    .acct_balance   (acct_balance),
    .lang_valid     (lang_valid),
    .language       (language),
    .pin_valid      (pin_valid),
    .pin_ok         (pin_ok),
    .op_valid       (op_valid),
    .operation      (operation),
    .value          (value),
    .another_valid  (another_valid),
    .another_service(another_service),
    .balance        (balance),
    .lang_sel       (lang_sel),
    .op_done        (op_done),
    .error          (error),
    .error_code     (error_code),
    .card_eject     (card_eject),
    .card_retain    (card_retain),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] ev(input logic [3:0] k, input logic [2:0] c,
                                     input logic [BW-1:0] b);
    return {k, c, b};
  endfunction

  // Every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (op_done || error || card_eject || card_retain) begin
      obs_v = {op_done, error, card_eject, card_retain, error_code, balance};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL event: got %h expected %h", obs_v, exp_v);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      tick();
      if (card_eject || card_retain) card_in = 1'b0;
    end
    chk(tag, exp_q.size(), 0);
    tick();
  endtask

  task automatic start_session(input logic [BW-1:0] bal, input logic lang);
    acct_balance = bal;
    card_in = 1'b1;
    tick();
    lang_valid = 1'b1; language = lang;
    tick();
    lang_valid = 1'b0;
    pin_valid = 1'b1; pin_ok = 1'b1;
    tick();
    pin_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [BW-1:0] val,
                       input logic [3:0] k, input logic [2:0] c, input logic [BW-1:0] b);
    op_valid = 1'b1; operation = op; value = val;
    exp_q.push_back(ev(k, c, b));
    tick();
    op_valid = 1'b0;
    if (op != 2'b11) tick();
  endtask

  task automatic answer(input logic svc);
    another_valid = 1'b1; another_service = svc;
    tick();
    another_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_balance", balance, 0);
    chk("rst_code", error_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lang", lang_sel, 0);
    chk("rst_pulses", {op_done, error, card_eject, card_retain}, 0);

    // basic withdraw then eject
    start_session(20'd1000, 1'b0);
    chk("s1_busy", busy, 1);
    chk("s1_bal_loaded", balance, 1000);
    do_op(2'b00, 20'd300, K_DONE, 3'd0, 20'd700);
    chk("s1_balance", balance, 700);
    exp_q.push_back(ev(K_EJ, 3'd0, 20'd700));
    answer(1'b0);
    drain("s1_drain", 6);
    chk("s1_idle", busy, 0);

    // three wrong PINs retain the card
    acct_balance = 20'd1234;
    card_in = 1'b1;
    tick();
    lang_valid = 1'b1; language = 1'b1;
    tick();
    lang_valid = 1'b0;
    chk("s2_lang_sel", lang_sel, 1);
    pin_valid = 1'b1; pin_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(K_ERR, 3'd1, 20'd1234));
      tick();
    end
    pin_valid = 1'b0;
    exp_q.push_back(ev(K_RET, 3'd1, 20'd1234));
    drain("s2_drain", 8);
    chk("s2_idle", busy, 0);

    // insufficient funds, then session limit
    start_session(20'd1000, 1'b0);
    do_op(2'b00, 20'd1500, K_ERR, 3'd2, 20'd1000);
    answer(1'b1);
    do_op(2'b00, 20'd300, K_DONE, 3'd2, 20'd700);
    answer(1'b1);
    do_op(2'b00, 20'd300, K_ERR, 3'd3, 20'd700);
    chk("s3_balance", balance, 700);
    exp_q.push_back(ev(K_EJ, 3'd3, 20'd700));
    answer(1'b0);
    drain("s3_drain", 6);

    // deposit overflow at the top of the range, inquiry, illegal op, timeout
    start_session(20'hFFFFA, 1'b0);
    do_op(2'b01, 20'd10, K_ERR, 3'd4, 20'hFFFFA);
    answer(1'b1);
    do_op(2'b01, 20'd5, K_DONE, 3'd4, 20'hFFFFF);
    chk("s4_balance_max", balance, 20'hFFFFF);
    answer(1'b1);
    do_op(2'b10, 20'd0, K_DONE, 3'd4, 20'hFFFFF);
    answer(1'b1);
    do_op(2'b11, 20'd1, K_ERR, 3'd6, 20'hFFFFF);
    exp_q.push_back(ev(K_ERR, 3'd5, 20'hFFFFF));
    exp_q.push_back(ev(K_EJ, 3'd5, 20'hFFFFF));
    repeat (15) tick();
    chk("s5_no_early_timeout", error, 0);
    tick();
    chk("s5_timeout_pulse", error, 1);
    chk("s5_timeout_code", error_code, 5);
    drain("s5_drain", 6);

    // valid input on the expiry cycle beats the timeout
    start_session(20'd50, 1'b0);
    repeat (15) tick();
    do_op(2'b10, 20'd0, K_DONE, 3'd0, 20'd50);
    chk("s5_no_timeout", error_code, 0);
    exp_q.push_back(ev(K_EJ, 3'd0, 20'd50));
    answer(1'b0);
    drain("s5b_drain", 6);

    // reset in the middle of a withdrawal
    start_session(20'd900, 1'b1);
    do_op(2'b11, 20'd1, K_ERR, 3'd6, 20'd900);
    op_valid = 1'b1; operation = 2'b00; value = 20'd100;
    tick();
    op_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    card_in = 1'b0;
    chk("s6_rst_balance", balance, 0);
    chk("s6_rst_code", error_code, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_lang", lang_sel, 0);
    chk("s6_rst_pulses", {op_done, error, card_eject, card_retain}, 0);
    tick();

    // card pulled during PIN entry
    acct_balance = 20'd777;
    card_in = 1'b1;
    tick();
    lang_valid = 1'b1; language = 1'b0;
    tick();
    lang_valid = 1'b0;
    pin_valid = 1'b1; pin_ok = 1'b0;
    exp_q.push_back(ev(K_ERR, 3'd1, 20'd777));
    tick();
    pin_valid = 1'b0;
    card_in = 1'b0;
    tick();
    chk("s6_drop_busy", busy, 0);
    chk("s6_drop_balance", balance, 777);
    chk("s6_drop_code", error_code, 1);
    repeat (4) tick();
    chk("s6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
